// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: mode decoding and FSM state encoding.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  function automatic logic cpol(input int mode);
    return 1'((mode / 2) % 2);
  endfunction

  function automatic logic cpha(input int mode);
    return 1'(mode % 2);
  endfunction

  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input int mode);
    return cpol(mode) == cpha(mode);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin-side and client-side signals of the SPI target, grouped for port connection.
interface spi_slave_if #(
  parameter int SPI_WIDTH = 8
);
  logic                 sck;
  logic                 cs_n;
  logic                 mosi;
  logic                 miso;
  logic                 miso_oe;
  logic [SPI_WIDTH-1:0] tx_data;
  logic                 tx_load;
  logic                 tx_ready;
  logic [SPI_WIDTH-1:0] rx_data;
  logic                 rx_valid;
  logic                 busy;
  logic                 frame_err;
  logic                 tx_underrun;

  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_load,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );

  modport master (
    output sck, cs_n, mosi, tx_data, tx_load,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );
endinterface

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with one-clock rise/fall pulses.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      sync_p2 <= RST_VAL;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign dout = sync_p1;
  assign rise = sync_p1 & ~sync_p2;
  assign fall = ~sync_p1 & sync_p2;
endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled SCK/CS_N/MOSI, SPI_WIDTH-bit words in, pre-loaded
// response words out on MISO, all four modes, MSB- or LSB-first.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE  = 3,
  parameter int SPI_WIDTH = 8,
  parameter int SPI_MSB   = 0
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);
  localparam logic CPOL_L   = cpol(SPI_MODE);
  localparam logic CPHA_L   = cpha(SPI_MODE);
  localparam logic SMP_RISE = sample_on_rise(SPI_MODE);
  localparam int   CW       = $clog2(SPI_WIDTH);

  typedef logic [SPI_WIDTH-1:0] word_t;

  function automatic logic head_bit(input word_t w);
    return (SPI_MSB != 0) ? w[SPI_WIDTH-1] : w[0];
  endfunction

  function automatic word_t advance(input word_t w);
    return (SPI_MSB != 0) ? {w[SPI_WIDTH-2:0], 1'b0} : {1'b0, w[SPI_WIDTH-1:1]};
  endfunction

  logic sck_s, sck_rise, sck_fall, cs_s, cs_rise, cs_fall;
  logic mosi_p0, mosi_p1, settle_p0, settle_p1, armed_q;

  sync_edge #(.RST_VAL(CPOL_L)) u_sck (
    .clk(clk), .rst(rst), .din(bus.sck), .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(bus.cs_n), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // Stage p0/p1: mosi synchroniser; armed_q waits until the cs_n synchroniser
  // reflects a real high level, so a frame cut by reset is not re-entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_p0   <= 1'b0;
      mosi_p1   <= 1'b0;
      settle_p0 <= 1'b0;
      settle_p1 <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      mosi_p0   <= bus.mosi;
      mosi_p1   <= mosi_p0;
      settle_p0 <= 1'b1;
      settle_p1 <= settle_p0;
      armed_q   <= armed_q | (settle_p1 & cs_s);
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  word_t         rx_shift_q, rx_data_q, rx_next;
  word_t         tx_buf_q, tx_shift_q, tx_word;
  logic          rx_valid_q, frame_err_q, tx_ready_q, tx_underrun_q, miso_q;
  logic          sck_edge, sample_ev, shift_ev, word_done, word_start, busy_w;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall && armed_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
    if (cs_rise) state_d = ST_IDLE;
  end

  // CPHA=0 pre-drives the first bit at word start, so the shift edge seen
  // while the counter is still 0 is skipped.
  assign sck_edge   = sck_rise | sck_fall;
  assign sample_ev  = (state_q == ST_SHIFT) && sck_edge && (sck_s == SMP_RISE);
  assign shift_ev   = (state_q == ST_SHIFT) && sck_edge && (sck_s != SMP_RISE)
                      && (CPHA_L || (cnt_q != '0));
  assign word_done  = sample_ev && (cnt_q == CW'(SPI_WIDTH - 1));
  assign word_start = !cs_rise && ((state_q == ST_LOAD) || ((state_q == ST_SHIFT) && rx_valid_q));
  assign rx_next    = (SPI_MSB != 0) ? {rx_shift_q[SPI_WIDTH-2:0], mosi_p1}
                                     : {mosi_p1, rx_shift_q[SPI_WIDTH-1:1]};
  assign tx_word    = tx_ready_q ? '0 : tx_buf_q;

  // Receive path: a word completing on the cs_n rise cycle is still delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= word_done;
      frame_err_q <= cs_rise && (cnt_q != '0) && !word_done;
      if (word_done) rx_data_q <= rx_next;
      if (cs_rise || word_done) begin
        cnt_q      <= '0;
        rx_shift_q <= '0;
      end else if (sample_ev) begin
        cnt_q      <= cnt_q + CW'(1);
        rx_shift_q <= rx_next;
      end
    end
  end

  // Transmit path: holding register, shift register and miso flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      tx_shift_q    <= '0;
      miso_q        <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_underrun_q <= word_start && tx_ready_q;
      if (word_start && !tx_ready_q) begin
        tx_ready_q <= 1'b1;
      end else if (bus.tx_load && tx_ready_q) begin
        tx_buf_q   <= bus.tx_data;
        tx_ready_q <= 1'b0;
      end
      if (cs_rise) begin
        tx_shift_q <= '0;
        miso_q     <= 1'b0;
      end else if (word_start) begin
        if (CPHA_L) begin
          tx_shift_q <= tx_word;
        end else begin
          miso_q     <= head_bit(tx_word);
          tx_shift_q <= advance(tx_word);
        end
      end else if (shift_ev) begin
        miso_q     <= head_bit(tx_shift_q);
        tx_shift_q <= advance(tx_shift_q);
      end
    end
  end

  assign busy_w          = armed_q & ~cs_s;
  assign bus.busy        = busy_w;
  assign bus.miso_oe     = busy_w;
  assign bus.miso        = busy_w & miso_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.tx_underrun = tx_underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-3/LSB-first and a mode-0/MSB-first instance
// driven by one bit-banged master, with an rx word scoreboard.
module tb_spi_slave;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic use3 = 1'b1;
  logic sck_pin = 1'b1;
  logic cs_pin = 1'b1;
  logic mosi_pin = 1'b0;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_unr = 0;
  int rd_idx = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  spi_slave_if #(.SPI_WIDTH(8)) if3 ();
  spi_slave_if #(.SPI_WIDTH(8)) if0 ();

  spi_slave #(.SPI_MODE(3), .SPI_WIDTH(8), .SPI_MSB(0)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  spi_slave #(.SPI_MODE(0), .SPI_WIDTH(8), .SPI_MSB(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  assign if3.sck  = use3 ? sck_pin : 1'b1;
  assign if3.cs_n = use3 ? cs_pin : 1'b1;
  assign if3.mosi = mosi_pin;
  assign if0.sck  = use3 ? 1'b0 : sck_pin;
  assign if0.cs_n = use3 ? 1'b1 : cs_pin;
  assign if0.mosi = mosi_pin;

  wire       m_miso     = use3 ? if3.miso : if0.miso;
  wire       m_oe       = use3 ? if3.miso_oe : if0.miso_oe;
  wire       m_ready    = use3 ? if3.tx_ready : if0.tx_ready;
  wire [7:0] m_rx_data  = use3 ? if3.rx_data : if0.rx_data;
  wire       m_rx_valid = use3 ? if3.rx_valid : if0.rx_valid;
  wire       m_busy     = use3 ? if3.busy : if0.busy;
  wire       m_ferr     = use3 ? if3.frame_err : if0.frame_err;
  wire       m_unr      = use3 ? if3.tx_underrun : if0.tx_underrun;

  always @(negedge clk) begin
    if (m_rx_valid) begin
      got_q.push_back(m_rx_data);
      n_valid++;
    end
    if (m_ferr) n_ferr++;
    if (m_unr) n_unr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic load(input logic [7:0] d);
    if (use3) begin
      if3.tx_data = d; if3.tx_load = 1'b1; tick(1); if3.tx_load = 1'b0;
    end else begin
      if0.tx_data = d; if0.tx_load = 1'b1; tick(1); if0.tx_load = 1'b0;
    end
  endtask

  task automatic start_frame();
    cs_pin = 1'b0;
    tick(H);
  endtask

  task automatic end_frame();
    if (!use3) begin
      sck_pin = 1'b0;
      tick(H);
    end
    cs_pin = 1'b1;
    tick(H);
  endtask

  // Each bit: shift-side edge (SCK low) then sampling rise, where miso is captured.
  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] got);
    int idx;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = use3 ? i : 7 - i;
      sck_pin = 1'b0;
      mosi_pin = w[idx];
      tick(H);
      got[idx] = m_miso;
      sck_pin = 1'b1;
      tick(H);
    end
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e;
    check({tag, "_count"}, got_q.size() - rd_idx, exp_q.size());
    while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
      e = exp_q.pop_front();
      check(tag, got_q[rd_idx], e);
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = got_q.size();
  endtask

  initial begin
    logic [7:0] got;
    int v0, f0, u0;
    if3.tx_data = '0; if3.tx_load = 1'b0;
    if0.tx_data = '0; if0.tx_load = 1'b0;
    tick(3);
    check("rst_miso", m_miso, 0);
    check("rst_oe", m_oe, 0);
    check("rst_ready", m_ready, 1);
    check("rst_rx_data", m_rx_data, 0);
    check("rst_rx_valid", m_rx_valid, 0);
    check("rst_busy", m_busy, 0);
    check("rst_ferr", m_ferr, 0);
    check("rst_unr", m_unr, 0);
    rst = 1'b0;
    tick(4);

    // Mode 3, LSB first
    load(8'hA5);
    check("t1_ready_loaded", m_ready, 0);
    u0 = n_unr; v0 = n_valid;
    start_frame();
    check("t1_busy", m_busy, 1);
    check("t1_oe", m_oe, 1);
    check("t1_ready_after_load", m_ready, 1);
    check("t1_no_unr", n_unr - u0, 0);
    exp_q.push_back(8'h3C);
    xfer(8'h3C, 8, got);
    check("t1_miso_word", got, 8'hA5);
    end_frame();
    check_rx("t1_rx");
    check("t1_valid_pulses", n_valid - v0, 1);
    check("t1_busy_end", m_busy, 0);
    check("t1_oe_end", m_oe, 0);

    // Mode 0, MSB first
    sck_pin = 1'b0; use3 = 1'b0;
    tick(4);
    load(8'h81);
    start_frame();
    check("t2_miso_first", m_miso, 1);
    exp_q.push_back(8'hF0);
    xfer(8'hF0, 8, got);
    check("t2_miso_word", got, 8'h81);
    end_frame();
    check_rx("t2_rx");

    // Burst of two words in mode 3, buffer refilled during the first
    sck_pin = 1'b1; use3 = 1'b1;
    tick(4);
    load(8'hC3);
    v0 = n_valid; f0 = n_ferr;
    start_frame();
    load(8'h99);
    check("t3_ready_refill", m_ready, 0);
    exp_q.push_back(8'h11);
    xfer(8'h11, 8, got);
    check("t3_miso_word1", got, 8'hC3);
    exp_q.push_back(8'h22);
    xfer(8'h22, 8, got);
    check("t3_miso_word2", got, 8'h99);
    end_frame();
    check_rx("t3_rx");
    check("t3_valid_pulses", n_valid - v0, 2);
    check("t3_no_ferr", n_ferr - f0, 0);

    // Abort after 5 bits; buffered response survives into the next frame
    v0 = n_valid; f0 = n_ferr;
    start_frame();
    load(8'hE7);
    xfer(8'hFF, 5, got);
    end_frame();
    check("t4_ferr", n_ferr - f0, 1);
    check("t4_no_valid", n_valid - v0, 0);
    check("t4_rx_hold", m_rx_data, 8'h22);
    check("t4_buf_kept", m_ready, 0);
    check_rx("t4_abort_rx");
    start_frame();
    exp_q.push_back(8'h5A);
    xfer(8'h5A, 8, got);
    check("t4_miso_kept", got, 8'hE7);
    end_frame();
    check_rx("t4_rx");

    // Underrun
    u0 = n_unr; v0 = n_valid;
    start_frame();
    check("t5_unr_pulse", n_unr - u0, 1);
    exp_q.push_back(8'h96);
    xfer(8'h96, 8, got);
    check("t5_miso_zero", got, 8'h00);
    end_frame();
    check_rx("t5_rx");
    check("t5_valid", n_valid - v0, 1);

    // Reset after bit 3
    start_frame();
    xfer(8'h0F, 3, got);
    rst = 1'b1;
    tick(1);
    check("t6_rst_miso", m_miso, 0);
    check("t6_rst_oe", m_oe, 0);
    check("t6_rst_busy", m_busy, 0);
    check("t6_rst_ready", m_ready, 1);
    check("t6_rst_rx_data", m_rx_data, 0);
    check("t6_rst_valid", m_rx_valid, 0);
    rst = 1'b0;
    v0 = n_valid; f0 = n_ferr;
    xfer(8'hF0, 5, got);
    check("t6_ignored_busy", m_busy, 0);
    end_frame();
    check("t6_no_valid", n_valid - v0, 0);
    check("t6_no_ferr", n_ferr - f0, 0);
    check_rx("t6_ignored_rx");
    v0 = n_valid;
    start_frame();
    exp_q.push_back(8'hC5);
    xfer(8'hC5, 8, got);
    end_frame();
    check_rx("t6_rx");
    check("t6_valid", n_valid - v0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
